// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform scheduler.
//  - default widths / latencies used as parameter defaults by the scheduler
//  - FSM state encoding (IDLE / RUN / DRAIN)
//  - waveform ROM index constants
package dds_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int NWAVE_DEF   = 4;
    localparam int ROM_LAT_DEF = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_RUN   = S_RUN,
        ST_DRAIN = S_DRAIN
    } state_t;

    localparam int WAVE_SAW    = 0;
    localparam int WAVE_SINE   = 1;
    localparam int WAVE_SQUARE = 2;
    localparam int WAVE_TRI    = 3;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator for the DDS scheduler.
// Ports:
//  clk, rst  : clock, synchronous active-high reset
//  clear     : force acc to 0 on the next edge (new burst)
//  en        : advance acc by fword on the next edge
//  fword     : frequency tuning word
//  acc       : current phase (registered)
//  carry     : combinational; 1 when the advance happening this cycle wraps
//              past 2^ACC_W, i.e. one full waveform period completes
module dds_phase_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [ACC_W-1:0] fword,
    output logic [ACC_W-1:0] acc,
    output logic             carry
);

    logic [ACC_W:0] sum;

    assign sum   = {1'b0, acc} + {1'b0, fword};
    assign carry = en & sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/dds_wave_scheduler.sv
// DDS waveform scheduler: accepts a burst command, runs the phase accumulator,
// drives the shared ROM address plus a one-hot ROM enable, and realigns the
// selected ROM output into a valid-qualified sample stream.
//
// Handshake: a command is taken on a cycle where cmd_valid & cmd_ready are both
// high; cmd_ready is high only in IDLE, so commands offered while busy simply
// wait (nothing is queued).
//
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  cmd_valid/ready, cmd_wave, cmd_fword, cmd_periods   burst command
//  stop          level abort, sampled in RUN
//  rom_addr      shared ROM address (top bits of the accumulator)
//  wave_en       one-hot enable of the selected ROM
//  rom_q         packed ROM outputs, ROM i at [i*DATA_W +: DATA_W]
//  q, q_valid    registered sample stream (q is 0 whenever q_valid is 0)
//  busy          state != IDLE
//  done          one-cycle pulse when a burst has fully drained
//  fsm_state     current FSM state, for observation
module dds_wave_scheduler
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NWAVE   = NWAVE_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF,
    localparam int WSEL_W = (NWAVE > 1) ? $clog2(NWAVE) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WSEL_W-1:0]       cmd_wave,
    input  logic [ACC_W-1:0]        cmd_fword,
    input  logic [CNT_W-1:0]        cmd_periods,
    input  logic                    stop,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic [NWAVE-1:0]        wave_en,
    input  logic [NWAVE*DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0]       q,
    output logic                    q_valid,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              fsm_state
);

    localparam int DRAIN_W = $clog2(ROM_LAT + 2);

    state_t              state;
    state_t              state_n;
    logic [WSEL_W-1:0]   wave_r;
    logic [ACC_W-1:0]    fword_r;
    logic [CNT_W-1:0]    periods_r;
    logic [CNT_W-1:0]    cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [ROM_LAT-1:0]  vpipe;

    logic                accept;
    logic                run;
    logic                last_period;
    logic                acc_clear;
    logic                acc_en;
    logic                carry;
    logic [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]   rom_sel;
    logic                vld_aligned;
    logic                rom_hold;

    dds_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .en    (acc_en),
        .fword (fword_r),
        .acc   (acc),
        .carry (carry)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign run       = (state == ST_RUN);
    assign accept    = cmd_valid & cmd_ready;
    assign rom_addr  = acc[ACC_W-1 -: ADDR_W];
    assign fsm_state = state;

    // The carry of this cycle completes period cnt+1; if that is the
    // requested count, the address issued this cycle is the final one.
    assign last_period = (periods_r != '0) && carry &&
                         ((cnt + CNT_W'(1)) == periods_r);

    // ----------------------------------------------------------------
    // FSM next state
    // ----------------------------------------------------------------
    always_comb begin
        state_n   = state;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_n   = ST_RUN;
                    acc_clear = 1'b1;
                end
            end
            ST_RUN: begin
                acc_en = 1'b1;
                // stop and the final carry together still give one DRAIN
                if (stop || last_period) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(ROM_LAT)) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------------
    // FSM state, command latch, period counter, done pulse
    // ----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wave_r    <= '0;
            fword_r   <= '0;
            periods_r <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            done      <= (state == ST_DRAIN) && (state_n == ST_IDLE);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            if (accept) begin
                wave_r    <= cmd_wave;
                fword_r   <= cmd_fword;
                periods_r <= cmd_periods;
                cnt       <= '0;
            end else if (run && carry && (cnt != {CNT_W{1'b1}})) begin
                // saturate so a long continuous burst never wraps
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // ----------------------------------------------------------------
    // ROM enable: on while issuing, and for ROM_LAT cycles of DRAIN so
    // the last issued address makes it through the ROM register.
    // ----------------------------------------------------------------
    assign rom_hold = run ||
                      ((state == ST_DRAIN) && (drain_cnt < DRAIN_W'(ROM_LAT)));

    always_comb begin
        wave_en = '0;
        if (rom_hold) begin
            for (int i = 0; i < NWAVE; i++) begin
                if (wave_r == WSEL_W'(i)) begin
                    wave_en[i] = 1'b1;
                end
            end
        end
    end

    // selected ROM output; an out-of-range index selects nothing
    always_comb begin
        rom_sel = '0;
        for (int i = 0; i < NWAVE; i++) begin
            if (wave_r == WSEL_W'(i)) begin
                rom_sel = rom_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // ----------------------------------------------------------------
    // Issue-valid pipeline: delayed ROM_LAT cycles it lines up with the
    // ROM data for that address, then one more register stage forms q.
    // ----------------------------------------------------------------
    assign vld_aligned = vpipe[ROM_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            vpipe[0] <= run;
            for (int i = 1; i < ROM_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            q_valid <= vld_aligned;
            q       <= vld_aligned ? rom_sel : '0;
        end
    end

endmodule
